// File: rtl/branch_pred_tracker.sv
// In-flight conditional branch tracker: a small FIFO of {PHT index, prediction}
// that feeds PHT updates and mispredict redirects. Optional gshare: BP_GSHARE_EN.
//
// Ports:
//   clk, reset (async, active-low)
//   fetch side  : BranchF, pcF, pht_taken -> pht_indexF, predF, stallF
//   execute side: BranchE, br_actualE, flushE
//                 -> pht_upd, pht_indexE, br_actual_out, mispredE
//   status      : underflow (sticky until reset)
module branch_pred_tracker #(
   parameter int DEPTH = 4,
   parameter int GHR_W = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             BranchF,
   input  logic [31:0]      pcF,
   input  logic             pht_taken,
   output logic [GHR_W-1:0] pht_indexF,
   output logic             predF,
   output logic             stallF,
   input  logic             BranchE,
   input  logic             br_actualE,
   input  logic             flushE,
   output logic             pht_upd,
   output logic [GHR_W-1:0] pht_indexE,
   output logic             br_actual_out,
   output logic             mispredE,
   output logic             underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = DEPTH[PW:0];

   logic [GHR_W-1:0] mem_idx  [DEPTH];
   logic             mem_pred [DEPTH];

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW:0]   occ;

   logic empty;
   logic pop_v;
   logic push_ok;
   logic unused_pc;

   assign unused_pc = ^{pcF[31:GHR_W+2], pcF[1:0]};

   assign empty   = (occ == '0);
   assign stallF  = (occ == FULL);
   assign predF   = pht_taken;
   assign pop_v   = BranchE && !empty;

   assign pht_upd       = pop_v;
   assign br_actual_out = br_actualE;
   assign pht_indexE    = empty ? '0 : mem_idx[rd_ptr];
   assign mispredE      = pop_v && (mem_pred[rd_ptr] != br_actualE);

   // A full queue refuses the push even if the head pops this cycle.
   assign push_ok = BranchF && !stallF && !flushE && !mispredE;

`ifdef BP_GSHARE_EN
   logic [GHR_W-1:0] ghr_spec;
   logic [GHR_W-1:0] ghr_commit;
   logic [GHR_W-1:0] commit_nxt;

   assign pht_indexF = pcF[GHR_W+1:2] ^ ghr_spec;
   assign commit_nxt = pop_v ? {ghr_commit[GHR_W-2:0], br_actualE}
                             : ghr_commit;

   // On a redirect the speculative history restarts from the
   // architectural history including the branch resolving now.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ghr_spec   <= '0;
         ghr_commit <= '0;
      end else begin
         ghr_commit <= commit_nxt;
         if (flushE || mispredE)
            ghr_spec <= commit_nxt;
         else if (push_ok)
            ghr_spec <= {ghr_spec[GHR_W-2:0], pht_taken};
      end
   end
`else
   assign pht_indexF = pcF[GHR_W+1:2];
`endif

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_idx[wr_ptr]  <= pht_indexF;
         mem_pred[wr_ptr] <= pht_taken;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occ       <= '0;
         underflow <= 1'b0;
      end else begin
         if (BranchE && empty)
            underflow <= 1'b1;
         if (flushE || mispredE) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
         end else begin
            if (push_ok)
               wr_ptr <= wr_ptr + 1'b1;
            if (pop_v)
               rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_v})
               2'b10:   occ <= occ + 1'b1;
               2'b01:   occ <= occ - 1'b1;
               default: occ <= occ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_branch_pred_tracker.sv
// Randomized bench for branch_pred_tracker against a queue-based model.
// Ports driven: all inputs; every output checked each cycle.
module tb_branch_pred_tracker;

   localparam int DEPTH = 4;
   localparam int GHR_W = 10;

   logic             clk;
   logic             reset;
   logic             BranchF;
   logic [31:0]      pcF;
   logic             pht_taken;
   logic [GHR_W-1:0] pht_indexF;
   logic             predF;
   logic             stallF;
   logic             BranchE;
   logic             br_actualE;
   logic             flushE;
   logic             pht_upd;
   logic [GHR_W-1:0] pht_indexE;
   logic             br_actual_out;
   logic             mispredE;
   logic             underflow;

   branch_pred_tracker #(.DEPTH(DEPTH), .GHR_W(GHR_W)) dut (
      .clk(clk), .reset(reset),
      .BranchF(BranchF), .pcF(pcF), .pht_taken(pht_taken),
      .pht_indexF(pht_indexF), .predF(predF), .stallF(stallF),
      .BranchE(BranchE), .br_actualE(br_actualE), .flushE(flushE),
      .pht_upd(pht_upd), .pht_indexE(pht_indexE),
      .br_actual_out(br_actual_out), .mispredE(mispredE),
      .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] idx;
      logic       pred;
   } ent_t;

   ent_t       q[$];
   logic       m_uf;
`ifdef BP_GSHARE_EN
   logic [9:0] m_spec;
   logic [9:0] m_commit;
`endif
   int n_chk;
   int n_fail;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_uf = 1'b0;
`ifdef BP_GSHARE_EN
      m_spec   = '0;
      m_commit = '0;
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset      = 1'b0;
      BranchF    = 1'b0;
      BranchE    = 1'b0;
      flushE     = 1'b0;
      br_actualE = 1'b0;
      pht_taken  = 1'($urandom);
      #1;
      model_clear();
      chk("rst_stall", 32'(stallF), 32'd0);
      chk("rst_upd", 32'(pht_upd), 32'd0);
      chk("rst_mis", 32'(mispredE), 32'd0);
      chk("rst_predF", 32'(predF), 32'(pht_taken));
      chk("rst_uf", 32'(underflow), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic step(input logic bf, input logic [31:0] pc,
                       input logic pt, input logic be,
                       input logic act, input logic fl);
      logic [9:0] e_idxF;
      logic [9:0] e_idxE;
      logic       e_stall;
      logic       e_pop;
      logic       e_mis;
      logic       e_push;
      @(negedge clk);
      BranchF    = bf;
      pcF        = pc;
      pht_taken  = pt;
      BranchE    = be;
      br_actualE = act;
      flushE     = fl;
      #1;
      e_stall = (q.size() == DEPTH);
`ifdef BP_GSHARE_EN
      e_idxF = pc[11:2] ^ m_spec;
`else
      e_idxF = pc[11:2];
`endif
      e_pop  = be && (q.size() > 0);
      e_idxE = 10'h0;
      e_mis  = 1'b0;
      if (q.size() > 0) begin
         e_idxE = q[0].idx;
         e_mis  = e_pop && (q[0].pred != act);
      end
      e_push = bf && !e_stall && !fl && !e_mis;
      chk("predF", 32'(predF), 32'(pt));
      chk("idxF", 32'(pht_indexF), 32'(e_idxF));
      chk("stallF", 32'(stallF), 32'(e_stall));
      chk("upd", 32'(pht_upd), 32'(e_pop));
      chk("idxE", 32'(pht_indexE), 32'(e_idxE));
      chk("act_out", 32'(br_actual_out), 32'(act));
      chk("mispred", 32'(mispredE), 32'(e_mis));
      chk("underflow", 32'(underflow), 32'(m_uf));
      @(posedge clk);
      if (be && q.size() == 0)
         m_uf = 1'b1;
      if (e_pop) begin
`ifdef BP_GSHARE_EN
         m_commit = {m_commit[8:0], act};
`endif
         void'(q.pop_front());
      end
      if (fl || e_mis) begin
         q.delete();
`ifdef BP_GSHARE_EN
         m_spec = m_commit;
`endif
      end else if (e_push) begin
         q.push_back('{idx: e_idxF, pred: pt});
`ifdef BP_GSHARE_EN
         m_spec = {m_spec[8:0], pt};
`endif
      end
   endtask

   initial begin
      n_chk      = 0;
      n_fail     = 0;
      reset      = 1'b0;
      BranchF    = 1'b0;
      pcF        = '0;
      pht_taken  = 1'b0;
      BranchE    = 1'b0;
      br_actualE = 1'b0;
      flushE     = 1'b0;
      model_clear();
      do_reset();

      // gshare index example, then BranchE on empty after reset
      step(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
      do_reset();
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      do_reset();

      // fill to full, dropped fifth push, matching pop
      for (int i = 0; i < 5; i++)
         step(1'b1, 32'h100 + 32'(i * 4), 1'(i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      // flush with head pop while three queued
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0);

      // mispredict with same-cycle push
      do_reset();
      step(1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h48, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'hFFC, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hFFC, 1'b1, 1'b0, 1'b0, 1'b0);

      // randomized phases, periodic mid-operation reset
      for (int i = 0; i < 3000; i++) begin
         int   mode;
         int   pf;
         int   pe;
         logic act;
         mode = (i / 250) % 3;
         pf   = (mode == 1) ? 75 : 50;
         pe   = (mode == 1) ? 25 : 40;
         act  = 1'($urandom);
         if (mode != 0 && q.size() > 0 && ($urandom % 10) != 0)
            act = q[0].pred;
         if (i % 500 == 499)
            do_reset();
         step(1'(($urandom % 100) < pf), $urandom, 1'($urandom),
              1'(($urandom % 100) < pe), act,
              1'(($urandom % 100) < 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_pred_tracker.md
BRANCH_PRED_TRACKER -- requirements
Module: branch_pred_tracker

Interface
REQ-001 Parameter DEPTH, default 4, in-flight branch entries; power of two, 2..16.
REQ-002 Parameter GHR_W, default 10, global history width; equals PHT index width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 BranchF  input  1  fetch issues a conditional branch this cycle (push request).
REQ-006 pcF  input  32  PC of the fetched branch.
REQ-007 pht_taken  input  1  PHT prediction read at pht_indexF.
REQ-008 pht_indexF  output  10  PHT read index for fetch.
REQ-009 predF  output  1  prediction forwarded to fetch; equals pht_taken.
REQ-010 stallF  output  1  tracker full; fetch holds the branch.
REQ-011 BranchE  input  1  oldest in-flight branch resolved in EX (pop request).
REQ-012 br_actualE  input  1  actual outcome of the resolving branch.
REQ-013 flushE  input  1  non-branch redirect (exception, jump); discards all in-flight entries.
REQ-014 pht_upd  output  1  PHT update strobe (drives PHT BranchE).
REQ-015 pht_indexE  output  10  PHT update index; head entry index.
REQ-016 br_actual_out  output  1  outcome forwarded to PHT br_actualE.
REQ-017 mispredE  output  1  head prediction differs from br_actualE; pipeline redirect.
REQ-018 underflow  output  1  sticky error: BranchE seen with queue empty.

Function
REQ-019 Circular FIFO of DEPTH entries, each {index[9:0], pred}; read/write pointers wrap modulo DEPTH; occupancy counter 0..DEPTH.
REQ-020 pht_indexF, predF, stallF, pht_upd, pht_indexE, br_actual_out, mispredE are combinational; zero-cycle latency.
REQ-021 stallF = (occupancy == DEPTH).
REQ-022 Push accepted when BranchF=1, stallF=0, flushE=0, mispredE=0; stores {pht_indexF, pht_taken} at write pointer.
REQ-023 Push while full is dropped; no state changes; a simultaneous pop does not free a slot for it that cycle.
REQ-024 Pop valid when BranchE=1 and occupancy>0; pht_upd=1, pht_indexE=head.index, br_actual_out=br_actualE, mispredE=(head.pred != br_actualE).
REQ-025 Speculative GHR ghr_spec shifts {ghr_spec[GHR_W-2:0], pht_taken} on each accepted push.
REQ-026 Committed GHR ghr_commit shifts {ghr_commit[GHR_W-2:0], br_actualE} on each valid pop.
REQ-027 On mispredE=1: queue emptied (pointers equal, occupancy 0), ghr_spec <= {ghr_commit[GHR_W-2:0], br_actualE}; same-cycle push discarded.
REQ-028 On flushE=1: queue emptied, ghr_spec <= ghr_commit; a same-cycle valid pop still updates the PHT and ghr_commit, and ghr_spec takes the post-pop ghr_commit.
REQ-029 Simultaneous valid push and pop without mispredict/flush: occupancy unchanged, both pointers advance.
REQ-030 BranchE with occupancy 0: pht_upd=0, mispredE=0, underflow set to 1 until reset.
REQ-031 pht_indexE is 0 when the queue is empty.

Reset
REQ-032 reset low clears asynchronously: pointers 0, occupancy 0, ghr_spec 0, ghr_commit 0, underflow 0; entry storage not cleared.
REQ-033 During and after reset with inputs low: stallF=0, pht_upd=0, mispredE=0, predF follows pht_taken.
REQ-034 Reset asserted mid-operation discards all in-flight entries; no PHT update issued for them.

Configuration
REQ-035 Macro BP_GSHARE_EN defined: pht_indexF = pcF[11:2] XOR ghr_spec; GHR logic per REQ-025..028.
REQ-036 BP_GSHARE_EN undefined: pht_indexF = pcF[11:2]; ghr_spec/ghr_commit not implemented; queue, mispredict and flush behaviour unchanged.

Verification
REQ-037 Gshare, ghr_spec=0x000, BranchF with pcF=0x0000_0040, pht_taken=1 -> pht_indexF=0x010, push, ghr_spec=0x001.
REQ-038 Four pushes with no pops (DEPTH=4) -> stallF=1; fifth BranchF dropped; BranchE br_actualE=pred -> pht_upd=1, pht_indexE=first index, stallF=0 next cycle.
REQ-039 Head pred=1, BranchE br_actualE=0 with BranchF=1 same cycle -> mispredE=1, push discarded, occupancy 0, ghr_spec={ghr_commit[8:0],0}.
REQ-040 BranchE at reset-exit with empty queue -> pht_upd=0, underflow=1 held until reset low.
REQ-041 Three entries queued, flushE=1 with valid pop of head -> pht_upd=1, occupancy 0, ghr_spec equals updated ghr_commit.
REQ-042 BP_GSHARE_EN undefined, pcF=0x0000_0FFC -> pht_indexF=0x3FF regardless of branch history.
